// File: rtl/rle_flash_fetch_if.sv
// rle_flash_fetch_if: consumer handshake and quad-SPI flash pins of rle_flash_fetch.
// The fetch block connects through the slave modport; the consumer/flash side uses master.
interface rle_flash_fetch_if;
   logic        stop_data;
   logic        read_next;
   logic        data_ready;
   logic [15:0] data;
   logic        spi_cs_n;
   logic        spi_sck;
   logic [3:0]  spi_data_out;
   logic [3:0]  spi_data_oe;
   logic [3:0]  spi_data_in;

   modport master (
      output stop_data, read_next, spi_data_in,
      input  data_ready, data, spi_cs_n, spi_sck, spi_data_out, spi_data_oe
   );

   modport slave (
      input  stop_data, read_next, spi_data_in,
      output data_ready, data, spi_cs_n, spi_sck, spi_data_out, spi_data_oe
   );
endinterface

// File: rtl/rle_flash_fetch.sv
// rle_flash_fetch: streams 16-bit RLE words from a quad-output SPI flash into a 2-entry FIFO.
// Optional macro RLE_FETCH_WRAP_EN: restart from START_ADDR when the fetch address reaches END_ADDR.
module rle_flash_fetch #(
   parameter logic [23:0] START_ADDR = 24'h000000,
   parameter logic [23:0] END_ADDR   = 24'h100000
) (
   input  logic             clk,
   input  logic             rstn,
   rle_flash_fetch_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      ADDR  = 3'd2,
      DUMMY = 3'd3,
      DATA  = 3'd4
   } state_t;

   localparam logic [7:0] READ_CMD = 8'h6B;

   state_t      state_r, state_s;
   logic [4:0]  cnt_r, cnt_s;
   logic        sck_r, sck_s;
   logic        cs_n_r, cs_n_s;
   logic [3:0]  dout_r, dout_s;
   logic [3:0]  oe_r, oe_s;
   logic [31:0] shift_r, shift_s;
   logic [11:0] nib_r, nib_s;
   logic        word_done_s;
   logic [15:0] word_s;

   logic [15:0] pend_r;
   logic        pend_valid_r;
   logic [15:0] mem_r [2];
   logic        rd_ptr_r, wr_ptr_r;
   logic [1:0]  count_r, count_s;
   logic [15:0] data_r;
   logic        data_ready_r;
   logic [23:0] addr_r, addr_next_s;
   logic        push_s, pop_s, stall_s, wrap_s;

   // A completed word waits in pend_r; it moves into the FIFO when a slot is free or being freed.
   assign pop_s       = bus.read_next && (count_r != 2'd0);
   assign push_s      = pend_valid_r && ((count_r != 2'd2) || pop_s);
   assign stall_s     = pend_valid_r && !push_s;
   assign count_s     = count_r + {1'b0, push_s} - {1'b0, pop_s};
   assign addr_next_s = addr_r + 24'd2;
   assign word_s      = {nib_r, bus.spi_data_in};

`ifdef RLE_FETCH_WRAP_EN
   assign wrap_s = push_s && (addr_next_s == END_ADDR);
`else
   logic unused_end_addr_s;
   assign wrap_s            = 1'b0;
   assign unused_end_addr_s = ^END_ADDR;
`endif

   // Next-state and SPI pin values; shifting and sampling happen only on SCK-falling clk edges.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      sck_s       = sck_r;
      cs_n_s      = cs_n_r;
      dout_s      = dout_r;
      oe_s        = oe_r;
      shift_s     = shift_r;
      nib_s       = nib_r;
      word_done_s = 1'b0;
      if (bus.stop_data || wrap_s) begin
         state_s = IDLE;
         cnt_s   = 5'd0;
         sck_s   = 1'b0;
         cs_n_s  = 1'b1;
         dout_s  = 4'd0;
         oe_s    = 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cnt_r == 5'd1) begin
                  state_s = CMD;
                  cnt_s   = 5'd0;
                  cs_n_s  = 1'b0;
                  shift_s = {READ_CMD, addr_r};
                  dout_s  = {3'b000, READ_CMD[7]};
                  oe_s    = 4'b0001;
               end else begin
                  cnt_s = cnt_r + 5'd1;
               end
            end
            CMD, ADDR: begin
               if (!sck_r) begin
                  sck_s = 1'b1;
               end else begin
                  sck_s   = 1'b0;
                  shift_s = {shift_r[30:0], 1'b0};
                  dout_s  = {3'b000, shift_r[30]};
                  if ((state_r == CMD) && (cnt_r == 5'd7)) begin
                     state_s = ADDR;
                     cnt_s   = 5'd0;
                  end else if ((state_r == ADDR) && (cnt_r == 5'd23)) begin
                     state_s = DUMMY;
                     cnt_s   = 5'd0;
                     dout_s  = 4'd0;
                     oe_s    = 4'd0;
                  end else begin
                     cnt_s = cnt_r + 5'd1;
                  end
               end
            end
            DUMMY: begin
               if (!sck_r) begin
                  sck_s = 1'b1;
               end else begin
                  sck_s = 1'b0;
                  if (cnt_r == 5'd7) begin
                     state_s = DATA;
                     cnt_s   = 5'd0;
                  end else begin
                     cnt_s = cnt_r + 5'd1;
                  end
               end
            end
            DATA: begin
               if (!sck_r) begin
                  // Hold SCK low while a finished word has nowhere to go.
                  if (stall_s) begin
                     sck_s = 1'b0;
                  end else begin
                     sck_s = 1'b1;
                  end
               end else begin
                  sck_s = 1'b0;
                  nib_s = word_s[11:0];
                  if (cnt_r == 5'd3) begin
                     word_done_s = 1'b1;
                     cnt_s       = 5'd0;
                  end else begin
                     cnt_s = cnt_r + 5'd1;
                  end
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = 5'd0;
               sck_s   = 1'b0;
               cs_n_s  = 1'b1;
               dout_s  = 4'd0;
               oe_s    = 4'd0;
            end
         endcase
      end
   end

   // FSM state and SPI pin registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
         cnt_r   <= 5'd0;
         sck_r   <= 1'b0;
         cs_n_r  <= 1'b1;
         dout_r  <= 4'd0;
         oe_r    <= 4'd0;
         shift_r <= 32'd0;
         nib_r   <= 12'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         sck_r   <= sck_s;
         cs_n_r  <= cs_n_s;
         dout_r  <= dout_s;
         oe_r    <= oe_s;
         shift_r <= shift_s;
         nib_r   <= nib_s;
      end
   end

   // Pending word, FIFO, registered head word and fetch address.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_r       <= 16'd0;
         pend_valid_r <= 1'b0;
         mem_r[0]     <= 16'd0;
         mem_r[1]     <= 16'd0;
         rd_ptr_r     <= 1'b0;
         wr_ptr_r     <= 1'b0;
         count_r      <= 2'd0;
         data_r       <= 16'd0;
         data_ready_r <= 1'b0;
         addr_r       <= START_ADDR;
      end else if (bus.stop_data) begin
         pend_valid_r <= 1'b0;
         rd_ptr_r     <= 1'b0;
         wr_ptr_r     <= 1'b0;
         count_r      <= 2'd0;
         data_ready_r <= 1'b0;
         addr_r       <= START_ADDR;
      end else begin
         if (word_done_s) begin
            pend_r       <= word_s;
            pend_valid_r <= 1'b1;
         end else if (push_s) begin
            pend_valid_r <= 1'b0;
         end
         if (push_s) begin
            mem_r[wr_ptr_r] <= pend_r;
            wr_ptr_r        <= ~wr_ptr_r;
            addr_r          <= wrap_s ? START_ADDR : addr_next_s;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         // data_r mirrors the FIFO head; it moves only on a pop or a push into an empty FIFO.
         if (pop_s && (count_r == 2'd2)) begin
            data_r <= mem_r[~rd_ptr_r];
         end else if (push_s && ((count_r == 2'd0) || (pop_s && (count_r == 2'd1)))) begin
            data_r <= pend_r;
         end
         count_r      <= count_s;
         data_ready_r <= (count_s != 2'd0);
      end
   end

   assign bus.spi_cs_n     = cs_n_r;
   assign bus.spi_sck      = sck_r;
   assign bus.spi_data_out = dout_r;
   assign bus.spi_data_oe  = oe_r;
   assign bus.data         = data_r;
   assign bus.data_ready   = data_ready_r;
endmodule
